// File: rtl/ghash_ctrl.sv
// ghash_ctrl: GCM authentication sequencer. Folds AAD/ciphertext blocks into
// the GHASH accumulator through an external gfmul stage, appends the length
// block and emits the unmasked GHASH value.
module ghash_ctrl #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         iStart,
    input  logic [0:127] iHashkey,
    input  logic         iBlkValid,
    output logic         oBlkReady,
    input  logic [0:127] iBlk,
    input  logic [4:0]   iBlkBytes,
    input  logic         iBlkIsAad,
    input  logic         iBlkLast,
    output logic [0:127] oMulCtext,
    output logic [0:127] oMulHashkey,
    input  logic [0:127] iMulResult,
    output logic [0:127] oTag,
    output logic         oTagValid,
    output logic         oBusy
);

    localparam int unsigned CW = $clog2(MUL_LAT + 2);
    localparam logic [0:127] ONES = '1;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WAIT,
        LEN,
        LWAIT,
        DONE
    } state_t;

    state_t        state;
    logic [0:127]  acc;
    logic [63:0]   len_a;
    logic [63:0]   len_c;
    logic          last_q;
    logic [CW-1:0] wcnt;

    logic [4:0]    n_eff;
    logic [7:0]    n_bits;
    logic [0:127]  keep;
    logic [0:127]  blk_m;
    logic          wait_done;

    // Clip the byte count to 16 and zero every byte past it
    always_comb begin
        n_eff     = (iBlkBytes > 5'd16) ? 5'd16 : iBlkBytes;
        n_bits    = {n_eff, 3'b000};
        keep      = ~(ONES >> n_bits);
        blk_m     = iBlk & keep;
        wait_done = (wcnt == CW'(MUL_LAT));
    end

    assign oBlkReady = (state == ACCEPT);

    // Sequencer: block intake, multiply waits, length block and tag output
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            len_a       <= '0;
            len_c       <= '0;
            last_q      <= 1'b0;
            wcnt        <= '0;
            oMulCtext   <= '0;
            oMulHashkey <= '0;
            oTag        <= '0;
            oTagValid   <= 1'b0;
            oBusy       <= 1'b0;
        end else if (iStart) begin
            // Start wins over any concurrent handshake; that block is dropped
            state       <= ACCEPT;
            acc         <= '0;
            len_a       <= '0;
            len_c       <= '0;
            oMulHashkey <= iHashkey;
            oTagValid   <= 1'b0;
            oBusy       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                ACCEPT: begin
                    if (iBlkValid) begin
                        last_q <= iBlkLast;
                        if (iBlkIsAad) begin
                            len_a <= len_a + 64'(n_bits);
                        end else begin
                            len_c <= len_c + 64'(n_bits);
                        end
                        if (n_eff != 5'd0) begin
                            oMulCtext <= acc ^ blk_m;
                            wcnt      <= '0;
                            state     <= WAIT;
                        end else if (iBlkLast) begin
                            state <= LEN;
                        end
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        acc   <= iMulResult;
                        state <= last_q ? LEN : ACCEPT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                LEN: begin
                    oMulCtext <= acc ^ {len_a, len_c};
                    wcnt      <= '0;
                    state     <= LWAIT;
                end
                LWAIT: begin
                    if (wait_done) begin
                        oTag      <= iMulResult;
                        oTagValid <= 1'b1;
                        oBusy     <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    oTagValid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
